// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================
// fp_pkg : shared types and constants for the FP divider/multiplier
// Rev 1.0
// ============================================================
package fp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FLAG_W  = 5;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Quiet NaN: positive, all-ones exponent, fraction MSB set; word width up to 64.
    function automatic logic [63:0] fp_canon_nan(input int unsigned exp_w, input int unsigned frac_w);
        logic [63:0] v;
        v = '0;
        for (int unsigned i = 0; i < exp_w; i++) begin
            v[frac_w + i] = 1'b1;
        end
        v[frac_w - 32'd1] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================
// fp_classify : combinational field decode of one FP operand
// Rev 1.0
// ============================================================
module fp_classify #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic [EXP_W+FRAC_W:0] i_op,
    output logic                  o_sign,
    output logic [EXP_W-1:0]      o_exp,
    output logic [FRAC_W:0]       o_mant,
    output logic                  o_is_zero,
    output logic                  o_is_inf,
    output logic                  o_is_qnan,
    output logic                  o_is_snan,
    output logic                  o_is_sub
);

    logic [FRAC_W-1:0] w_frac;
    logic              w_exp_zero;
    logic              w_exp_ones;
    logic              w_frac_zero;

    assign o_sign      = i_op[EXP_W+FRAC_W];
    assign o_exp       = i_op[EXP_W+FRAC_W-1:FRAC_W];
    assign w_frac      = i_op[FRAC_W-1:0];
    assign w_exp_zero  = (o_exp == '0);
    assign w_exp_ones  = (o_exp == '1);
    assign w_frac_zero = (w_frac == '0);

    assign o_mant    = {~w_exp_zero, w_frac};
    assign o_is_zero = w_exp_zero & w_frac_zero;
    assign o_is_sub  = w_exp_zero & ~w_frac_zero;
    assign o_is_inf  = w_exp_ones & w_frac_zero;
    assign o_is_qnan = w_exp_ones & w_frac[FRAC_W-1];
    assign o_is_snan = w_exp_ones & ~w_frac[FRAC_W-1] & ~w_frac_zero;

endmodule
`default_nettype wire

// File: rtl/fp_div_iter.sv
`default_nettype none
// ============================================================
// fp_div_iter : iterative restoring FP divider with RNE rounding
// Rev 1.0
// ============================================================
module fp_div_iter
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [EXP_W+FRAC_W:0]   i_a,
    input  logic [EXP_W+FRAC_W:0]   i_b,
    output logic                    o_valid,
    output logic [EXP_W+FRAC_W:0]   o_result,
    output logic [FLAG_W-1:0]       o_flags
);

    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int N     = FRAC_W + 3;
    localparam int CNT_W = $clog2(N + 1);
    localparam int EW    = EXP_W + 2;
    localparam int MW    = FRAC_W + 1;

    localparam logic [W-1:0]     C_NAN     = W'(fp_canon_nan(EXP_W, FRAC_W));
    localparam logic [EW-1:0]    C_BIAS    = EW'(fp_bias(EXP_W));
    localparam logic [EW-1:0]    C_EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [EW-1:0]    C_ONE     = EW'(1);
    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(N - 1);

    logic              a_sign, b_sign;
    logic [EXP_W-1:0]  a_exp, b_exp;
    logic [FRAC_W:0]   a_mant, b_mant;
    logic              a_is_zero, a_is_inf, a_is_qnan, a_is_snan, a_is_sub;
    logic              b_is_zero, b_is_inf, b_is_qnan, b_is_snan, b_is_sub;

    fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_a (
        .i_op(i_a), .o_sign(a_sign), .o_exp(a_exp), .o_mant(a_mant),
        .o_is_zero(a_is_zero), .o_is_inf(a_is_inf), .o_is_qnan(a_is_qnan),
        .o_is_snan(a_is_snan), .o_is_sub(a_is_sub)
    );

    fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_b (
        .i_op(i_b), .o_sign(b_sign), .o_exp(b_exp), .o_mant(b_mant),
        .o_is_zero(b_is_zero), .o_is_inf(b_is_inf), .o_is_qnan(b_is_qnan),
        .o_is_snan(b_is_snan), .o_is_sub(b_is_sub)
    );

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [W-1:0]      result_q, result_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [MW:0]       rem_q, rem_d;
    logic [MW-1:0]     div_q, div_d;
    logic [N-1:0]      quo_q, quo_d;
    logic [EW-1:0]     exp_q, exp_d;
    logic              sign_q, sign_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              w_a_zero, w_b_zero, w_sign, w_special, w_pre, w_accept;
    logic [W-1:0]      w_spec_res;
    logic [FLAG_W-1:0] w_spec_flags;
    logic [MW:0]       w_rem_init;
    logic [EW-1:0]     w_exp_init;

    // Subnormals count as zero everywhere in the decode below.
    always_comb begin
        w_a_zero     = a_is_zero | a_is_sub;
        w_b_zero     = b_is_zero | b_is_sub;
        w_sign       = a_sign ^ b_sign;
        w_special    = 1'b1;
        w_spec_res   = C_NAN;
        w_spec_flags = '0;
        if (a_is_snan | b_is_snan | (w_a_zero & w_b_zero) | (a_is_inf & b_is_inf)) begin
            w_spec_flags[FLAG_NV] = 1'b1;
        end else if (a_is_qnan | b_is_qnan) begin
            w_spec_res = C_NAN;
        end else if (a_is_inf) begin
            w_spec_res = {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (w_b_zero) begin
            w_spec_res            = {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            w_spec_flags[FLAG_DZ] = 1'b1;
        end else if (w_a_zero | b_is_inf) begin
            w_spec_res = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_special  = 1'b0;
            w_spec_res = '0;
        end
        w_pre      = (a_mant < b_mant);
        w_rem_init = w_pre ? {a_mant, 1'b0} : {1'b0, a_mant};
        w_exp_init = {2'b00, a_exp} - {2'b00, b_exp} + C_BIAS - EW'(w_pre);
    end

    logic              w_ge;
    logic [MW:0]       w_rem_sub;
    logic              w_guard, w_round, w_sticky, w_up, w_carry;
    logic [MW:0]       w_mant_r;
    logic [FRAC_W-1:0] w_frac_r;
    logic [EW-1:0]     w_exp_r;
    logic [W-1:0]      w_rnd_res;
    logic [FLAG_W-1:0] w_rnd_flags;

    always_comb begin
        w_ge      = (rem_q >= {1'b0, div_q});
        w_rem_sub = rem_q - (w_ge ? {1'b0, div_q} : {(MW+1){1'b0}});

        // quo_q = {hidden, fraction, guard, round}
        w_guard  = quo_q[1];
        w_round  = quo_q[0];
        w_sticky = |rem_q;
        w_up     = w_guard & (w_round | w_sticky | quo_q[2]);
        w_mant_r = {1'b0, quo_q[N-1:2]} + {{MW{1'b0}}, w_up};
        w_carry  = w_mant_r[MW];
        w_frac_r = w_carry ? {FRAC_W{1'b0}} : w_mant_r[FRAC_W-1:0];
        w_exp_r  = exp_q + EW'(w_carry);

        w_rnd_res            = {sign_q, w_exp_r[EXP_W-1:0], w_frac_r};
        w_rnd_flags          = '0;
        w_rnd_flags[FLAG_NX] = w_guard | w_round | w_sticky;
        if ($signed(w_exp_r) >= $signed(C_EXP_MAX)) begin
            w_rnd_res            = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            w_rnd_flags[FLAG_OF] = 1'b1;
            w_rnd_flags[FLAG_NX] = 1'b1;
        end else if ($signed(w_exp_r) < $signed(C_ONE)) begin
            w_rnd_res            = {sign_q, {(W-1){1'b0}}};
            w_rnd_flags[FLAG_UF] = 1'b1;
            w_rnd_flags[FLAG_NX] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        result_d = result_q;
        flags_d  = flags_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        w_accept = i_valid & ready_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (w_accept) begin
                    if (w_special) begin
                        state_d  = ST_DONE;
                        valid_d  = 1'b1;
                        result_d = w_spec_res;
                        flags_d  = w_spec_flags;
                    end else begin
                        state_d = ST_CALC;
                        rem_d   = w_rem_init;
                        div_d   = b_mant;
                        quo_d   = '0;
                        exp_d   = w_exp_init;
                        sign_d  = w_sign;
                        cnt_d   = '0;
                    end
                end
            end
            ST_CALC: begin
                rem_d = {w_rem_sub[MW-1:0], 1'b0};
                quo_d = {quo_q[N-2:0], w_ge};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d  = ST_DONE;
                valid_d  = 1'b1;
                result_d = w_rnd_res;
                flags_d  = w_rnd_flags;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_flags  = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_iter.sv
`default_nettype none
// ============================================================
// tb_fp_div_iter : directed + randomized checks of fp_div_iter (binary32)
// Rev 1.0
// ============================================================
module tb_fp_div_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a, i_b;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_flags;

    int n_checks = 0;
    int n_pass   = 0;

    fp_div_iter #(.EXP_W(8), .FRAC_W(23)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .o_result(o_result), .o_flags(o_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Reference: exact integer quotient with 26 significant bits plus sticky, then RNE.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [4:0] f, output bit spec);
        int          ea, eb, e;
        logic [22:0] fa, fb;
        bit          s, za, zb, ia, ib, na, nb, sna, snb, sticky, g, rd, up;
        longint unsigned ma, mb, num, q, rm, sig;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = a[22:0];        fb = b[22:0];
        s   = a[31] ^ b[31];
        za  = (ea == 0);               zb  = (eb == 0);
        ia  = (ea == 255) && (fa == 0); ib  = (eb == 255) && (fb == 0);
        na  = (ea == 255) && (fa != 0); nb  = (eb == 255) && (fb != 0);
        sna = na && !fa[22];           snb = nb && !fb[22];
        f = 5'b0; spec = 1'b1;
        if (sna || snb || (za && zb) || (ia && ib)) begin r = 32'h7FC00000; f = 5'b10000; end
        else if (na || nb)  r = 32'h7FC00000;
        else if (ia)        r = {s, 8'hFF, 23'h0};
        else if (zb) begin  r = {s, 8'hFF, 23'h0}; f = 5'b01000; end
        else if (za || ib)  r = {s, 31'h0};
        else begin
            spec = 1'b0;
            ma  = {40'd0, 1'b1, fa};
            mb  = {40'd0, 1'b1, fb};
            num = ma << 26;
            q   = num / mb;
            rm  = num % mb;
            e   = ea - eb + 127;
            if (q >= (64'd1 << 26)) begin
                sticky = (rm != 0) || q[0];
                q = q >> 1;
            end else begin
                sticky = (rm != 0);
                e = e - 1;
            end
            sig = q >> 2;
            g   = q[1];
            rd  = q[0];
            up  = g && (rd || sticky || sig[0]);
            sig = sig + longint'(up);
            if (sig == (64'd1 << 24)) begin
                sig = 64'd1 << 23;
                e   = e + 1;
            end
            if (e >= 255)    begin r = {s, 8'hFF, 23'h0}; f = 5'b00101; end
            else if (e <= 0) begin r = {s, 31'h0};        f = 5'b00011; end
            else begin
                r = {s, 8'(e), sig[22:0]};
                f = {4'b0, g | rd | sticky};
            end
        end
    endfunction

    // Drives one operation starting now, then measures edges from accept edge to o_valid.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [4:0] ef, input int elat, input bit pulse);
        logic [31:0] prev;
        bit          busy_ok;
        int          lat;
        prev    = o_result;
        busy_ok = 1'b1;
        i_a = a; i_b = b; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 40) begin
            if (o_ready !== 1'b0 || o_result !== prev) busy_ok = 1'b0;
            if (pulse && (lat == 5 || lat == 12)) begin
                i_a = 32'h3F800000; i_b = 32'h0; i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        i_valid = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_res"}, {32'h0, o_result}, {32'h0, er});
        chk({tag, "_flg"}, {59'h0, o_flags}, {59'h0, ef});
        if (elat != 0) chk({tag, "_busy"}, {63'h0, busy_ok}, 64'd1);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          sel;
        v   = $urandom;
        sel = $urandom_range(0, 19);
        case (sel)
            0:       v[30:23] = 8'h00;
            1: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) v[22:0] = 23'h0; end
            2:       v[30:23] = 8'($urandom_range(1, 20));
            3:       v[30:23] = 8'($urandom_range(235, 254));
            default: v[30:23] = 8'($urandom_range(90, 164));
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] er;
        logic [4:0]  ef;
        bit          sp;
        int          spurious;

        rst_n = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  {63'h0, o_ready}, 64'd1);
        chk("rst_valid",  {63'h0, o_valid}, 64'd0);
        chk("rst_result", {32'h0, o_result}, 64'd0);
        chk("rst_flags",  {59'h0, o_flags}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("div6_2",  32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27, 1'b0);
        run_op("div1_3",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 27, 1'b0);
        run_op("div1_1",  32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 27, 1'b0);
        run_op("dz",      32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 0, 1'b0);
        run_op("zz",      32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 0, 1'b0);
        run_op("ninf",    32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 0, 1'b0);
        run_op("snan",    32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 0, 1'b0);
        run_op("qnan",    32'h3F800000, 32'hFFC12345, 32'h7FC00000, 5'b00000, 0, 1'b0);
        run_op("fin_inf", 32'hC0000000, 32'h7F800000, 32'h80000000, 5'b00000, 0, 1'b0);
        run_op("ovf",     32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 27, 1'b0);
        run_op("unf",     32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 27, 1'b0);

        // Second op is issued during the DONE cycle of the first; stray pulses hit CALC.
        run_op("b2b_a",   32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27, 1'b0);
        run_op("b2b_b",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 27, 1'b1);

        i_a = 32'h40C00000; i_b = 32'h40000000; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ready",  {63'h0, o_ready}, 64'd1);
        chk("arst_valid",  {63'h0, o_valid}, 64'd0);
        chk("arst_result", {32'h0, o_result}, 64'd0);
        chk("arst_flags",  {59'h0, o_flags}, 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        spurious = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (o_valid) spurious++;
        end
        chk("arst_no_valid", 64'(spurious), 64'd0);
        run_op("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            ra = rand_op();
            rb = rand_op();
            ref_div(ra, rb, er, ef, sp);
            run_op($sformatf("rnd%0d", i), ra, rb, er, ef, sp ? 0 : 27, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_div_iter.md
# fp_div_iter

Parametrised iterative floating-point divider, successor to the fixed single-precision divider in the ALU. Computes a/b for IEEE-754 style operands of configurable exponent and fraction width. Uses one restoring-division step per cycle, with round-to-nearest-even, special-operand handling, exception flags and a valid/ready input handshake. Sits in the ALU beside the FP multiplier and is driven by the execute stage.

## Interface
- EXP_W, 8: exponent field width
- FRAC_W, 23: stored fraction width; word width W = 1+EXP_W+FRAC_W
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_valid  input  1  operands present
- o_ready  output  1  divider can accept; reset 1
- i_a  input  W  dividend
- i_b  input  W  divisor
- o_valid  output  1  one-cycle result strobe; reset 0
- o_result  output  W  quotient, held until the next result; reset 0
- o_flags  output  5  {NV, DZ, OF, UF, NX}, held with o_result; reset 0

One clock; reset is asynchronous and active-low (i_clk, i_rst_n).

## Operation
- States: IDLE, CALC, ROUND, DONE. Reset enters IDLE.
- o_ready = 1 in IDLE and DONE; 0 in CALC and ROUND.
- Accept occurs on i_valid & o_ready. i_valid while busy is ignored; no queueing.
- Subnormal inputs are flushed to signed zero. Subnormal results are flushed to signed zero.
- Sign of the result is sign_a ^ sign_b, except for NaN.
- Special cases resolve at accept and go straight to DONE:
  - Either input sNaN, 0/0, or inf/inf: result is canonical qNaN {0, all-ones exponent, 1, zeros}, flag NV.
  - Either input qNaN: result is canonical qNaN, no flag.
  - finite nonzero / 0: result is signed inf, flag DZ.
  - inf / finite: result is signed inf.
  - 0 / nonzero, or finite / inf: result is signed zero.
- Normal path, CALC:
  - Mantissas are {1, frac}.
  - The exponent is held signed, EXP_W+2 bits wide: ea − eb + bias, where bias = 2^(EXP_W−1) − 1.
  - If ma < mb, the dividend is pre-shifted left by 1 and the exponent is decremented.
  - CALC runs N = FRAC_W+3 restoring steps, one quotient bit per cycle. This produces the hidden bit, FRAC_W fraction bits, guard and round bits.
  - Sticky = (final remainder ≠ 0).
  - An iteration counter of ceil(log2(N+1)) bits ends CALC after exactly N cycles.
- ROUND: round-to-nearest-even.
  - If rounding carries out, the fraction becomes zero and the exponent is incremented.
  - Then range check on the exponent:
    - exp ≥ 2^EXP_W−1: result is signed inf, flags OF|NX.
    - exp ≤ 0: result is signed zero, flags UF|NX.
  - Otherwise NX = guard|round|sticky.
- DONE lasts one cycle with o_valid = 1, then returns to IDLE.
- A new accept in DONE goes directly to CALC (or to DONE for a special case), giving back-to-back operation.
- An asynchronous reset mid-operation aborts the operation. All outputs take their reset values and no o_valid is produced.

## Timing
- Normal latency: o_valid is high FRAC_W+4 cycles after the accept edge, i.e. 27 for the defaults.
- Special-case latency: o_valid is high in the cycle after the accept edge.
- o_result and o_flags change only on the edge that raises o_valid.
- Throughput: one normal division per FRAC_W+4 cycles.

## Structure
- Package fp_pkg holds:
  - State enum.
  - Flag bit indices NV=4, DZ=3, OF=2, UF=1, NX=0.
  - Bias and canonical-NaN constant functions of EXP_W and FRAC_W.
- Sub-module fp_classify: combinational decode of one operand into sign, exp, mant, is_zero, is_inf, is_qnan, is_snan, is_sub. It is instantiated twice and shared with the FP multiplier.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) -> 0x40400000, flags 0, o_valid exactly 27 cycles after accept, o_ready low in between.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, flags NX; also 0x3F800000 / 0x3F800000 -> 0x3F800000, flags 0.
- Specials, each with o_valid one cycle after accept:
  - 0x3F800000 / 0 -> 0x7F800000, DZ.
  - 0/0 -> 0x7FC00000, NV.
  - 0xFF800000 / 0x40000000 -> 0xFF800000, flags 0.
- Range: 0x7F000000 / 0x3E800000 -> 0x7F800000, OF|NX. 0x00800000 / 0x40000000 -> 0x00000000, UF|NX.
- Back-to-back: new i_valid in the DONE cycle is accepted. Second result arrives 27 cycles later. i_valid pulses during CALC are ignored.
- Reset asserted mid-CALC: outputs immediately 0, o_ready = 1. After release, a fresh 6/2 completes correctly with no spurious o_valid.
